// File: rtl/sram_rd_arb.sv
// sram_rd_arb: round-robin read arbiter in front of a two-port SRAM.
// NREQ requesters share the SRAM read port; results come back through a
// 2-entry {id, data} FIFO guarded by a credit check, so it never overflows.
// The write port is a straight pass-through from the single writer.
// Optional feature: define SRAM_RD_ARB_BYPASS_EN to forward same-cycle write
// data to a read of the same address instead of the SRAM output.
module sram_rd_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WADDR = 11,
    parameter int unsigned WWORD = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WADDR-1:0]     addr,
    output logic [NREQ-1:0]           gnt,
    input  logic                      wr_en,
    input  logic [WADDR-1:0]          wr_addr,
    input  logic [WWORD-1:0]          wr_data,
    output logic                      sram_cena,
    output logic [WADDR-1:0]          sram_aa,
    input  logic [WWORD-1:0]          sram_qa,
    output logic                      sram_cenb,
    output logic [WADDR-1:0]          sram_ab,
    output logic [WWORD-1:0]          sram_db,
    output logic                      rvalid,
    output logic [$clog2(NREQ)-1:0]   rid,
    output logic [WWORD-1:0]          rdata,
    input  logic                      rready
);

    localparam int unsigned IdW = $clog2(NREQ);
    localparam logic [IdW:0]   NreqW   = NREQ[IdW:0];
    localparam logic [IdW-1:0] LastIdx = IdW'(NREQ - 1);

    logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]    win;
    logic              any_req;
    logic              credit;
    logic              issue;
    logic [WADDR-1:0]  sel_addr;
    logic [WADDR-1:0]  aa_q;
    logic              inflight_q;
    logic [IdW-1:0]    inflight_id_q;
    logic [IdW-1:0]    fifo_id_q   [2];
    logic [WWORD-1:0]  fifo_data_q [2];
    logic              wptr_q, rptr_q;
    logic [1:0]        count_q, count_d;
    logic              push, pop;
    logic [WWORD-1:0]  push_data;
    logic [2*NREQ-1:0] req_rot;
    logic [IdW:0]      win_sum;
    logic [2:0]        occ;

    // Write port is a plain pass-through.
    assign sram_cenb = ~wr_en;
    assign sram_ab   = wr_addr;
    assign sram_db   = wr_data;

    // Result FIFO handshake and credit: at most two results outstanding,
    // counting the one already in flight and any pop this cycle.
    assign rvalid = (count_q != 2'd0);
    assign pop    = rvalid & rready;
    assign push   = inflight_q;
    assign occ    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit = (occ < 3'd2);
    assign any_req = |req;
    assign issue  = any_req & credit & ~rst;

    // Round-robin search: rotate req so rr_ptr sits at bit 0, take the first set bit.
    always_comb begin
        logic found;
        logic [IdW-1:0] off;
        found   = 1'b0;
        off     = '0;
        req_rot = {req, req} >> rr_ptr_q;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                off   = IdW'(i);
            end
        end
        win_sum = {1'b0, rr_ptr_q} + {1'b0, off};
        if (win_sum >= NreqW) begin
            win_sum = win_sum - NreqW;
        end
        win = win_sum[IdW-1:0];
    end

    // Grant vector, winning address and read-port drive.
    always_comb begin
        sel_addr = '0;
        gnt      = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (win == IdW'(i)) begin
                sel_addr = addr[i*WADDR +: WADDR];
                gnt[i]   = issue;
            end
        end
        sram_cena = ~issue;
        sram_aa   = issue ? sel_addr : aa_q;
    end

    // Pointer advances past the winner only when something is issued.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = (win == LastIdx) ? '0 : win + 1'b1;
        end
    end

    // FIFO occupancy: push and pop together leave the count unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

`ifdef SRAM_RD_ARB_BYPASS_EN
    logic             byp_hit_q;
    logic [WWORD-1:0] byp_data_q;

    // Capture a same-cycle write to the address being read; it wins over sram_qa.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_hit_q  <= issue & wr_en & (wr_addr == sel_addr);
            byp_data_q <= wr_data;
        end
    end

    assign push_data = byp_hit_q ? byp_data_q : sram_qa;
`else
    assign push_data = sram_qa;
`endif

    // Arbiter pointer, held read address and in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            aa_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= issue;
            if (issue) begin
                aa_q          <= sel_addr;
                inflight_id_q <= win;
            end
        end
    end

    // Result FIFO storage and pointers; reset discards everything queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_id_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (push) begin
                fifo_id_q[wptr_q]   <= inflight_id_q;
                fifo_data_q[wptr_q] <= push_data;
                wptr_q              <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
        end
    end

    // Head of FIFO drives the result; zero while empty.
    always_comb begin
        rid   = rvalid ? fifo_id_q[rptr_q]   : '0;
        rdata = rvalid ? fifo_data_q[rptr_q] : '0;
    end

    // Credit logic must make a push into a full FIFO unreachable.
    push_full_a: assert property (@(posedge clk) disable iff (rst) !(push && (count_q == 2'd2)));

endmodule

// File: tb/tb_sram_rd_arb.sv
// Self-checking bench for sram_rd_arb: directed scenarios plus random traffic,
// all compared against a transaction-level model (round-robin pick, outstanding
// result queue with ready times, array copy of memory contents).
module tb_sram_rd_arb;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WADDR = 11;
    localparam int unsigned WWORD = 128;
    localparam int unsigned DEPTH = 1 << WADDR;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WADDR-1:0] addr;
    logic [NREQ-1:0]       gnt;
    logic                  wr_en;
    logic [WADDR-1:0]      wr_addr;
    logic [WWORD-1:0]      wr_data;
    logic                  sram_cena;
    logic [WADDR-1:0]      sram_aa;
    logic [WWORD-1:0]      sram_qa;
    logic                  sram_cenb;
    logic [WADDR-1:0]      sram_ab;
    logic [WWORD-1:0]      sram_db;
    logic                  rvalid;
    logic [1:0]            rid;
    logic [WWORD-1:0]      rdata;
    logic                  rready;

    sram_rd_arb #(.NREQ(NREQ), .WADDR(WADDR), .WWORD(WWORD)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sram_cena(sram_cena), .sram_aa(sram_aa), .sram_qa(sram_qa),
        .sram_cenb(sram_cenb), .sram_ab(sram_ab), .sram_db(sram_db),
        .rvalid(rvalid), .rid(rid), .rdata(rdata), .rready(rready)
    );

    always #5 clk = ~clk;

    // Physical SRAM: registered read, read-first on address collision.
    logic [WWORD-1:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_cena) sram_qa <= sram_mem[sram_aa];
        if (!sram_cenb) sram_mem[sram_ab] <= sram_db;
    end

    // Reference model state.
    typedef struct {
        int unsigned      id;
        logic [WWORD-1:0] data;
        int               rdy;
    } res_t;

    res_t             exp_q [$];
    logic [WWORD-1:0] model_mem [DEPTH];
    int               ptr;
    int               cyc;
    bit               rst_prev;
    bit               aa_known;
    logic [WADDR-1:0] last_aa;
    logic [NREQ-1:0]  gnt_exp;
    int               gcount;
    int               checks;
    int               failures;

    task automatic check(input string tag, input logic [WWORD-1:0] got,
                         input logic [WWORD-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: compare at the negedge, advance the model, return at posedge+1.
    task automatic tick();
        int               w;
        int               j;
        bit               rv, pp, cr, iss;
        logic [WADDR-1:0] a;
        logic [WWORD-1:0] d;
        res_t             r;
        @(negedge clk);
        gnt_exp = '0;
        check("cenb", {127'd0, sram_cenb}, {127'd0, ~wr_en});
        if (wr_en) check("ab", {117'd0, sram_ab}, {117'd0, wr_addr});
        if (rst) begin
            check("rst_gnt", {124'd0, gnt}, '0);
            check("rst_cena", {127'd0, sram_cena}, 128'd1);
            if (rst_prev) begin
                check("rst_rvalid", {127'd0, rvalid}, '0);
                check("rst_rid", {126'd0, rid}, '0);
                check("rst_rdata", rdata, '0);
            end
            exp_q.delete();
            ptr = 0;
            aa_known = 1'b0;
        end else begin
            rv = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
            pp = rv && rready;
            cr = (int'(exp_q.size()) - int'(pp)) < 2;
            w = -1;
            if (cr) begin
                for (int i = 0; i < int'(NREQ); i++) begin
                    j = (ptr + i) % int'(NREQ);
                    if (w < 0 && req[j]) w = j;
                end
            end
            iss = (w >= 0);
            if (iss) gnt_exp = NREQ'(1) << w;
            check("gnt", {124'd0, gnt}, {124'd0, gnt_exp});
            check("cena", {127'd0, sram_cena}, {127'd0, !iss});
            if (iss) begin
                a = addr[w*WADDR +: WADDR];
                check("aa_issue", {117'd0, sram_aa}, {117'd0, a});
            end else if (aa_known) begin
                check("aa_hold", {117'd0, sram_aa}, {117'd0, last_aa});
            end
            check("rvalid", {127'd0, rvalid}, {127'd0, rv});
            if (rv) begin
                check("rid", {126'd0, rid}, 128'(exp_q[0].id));
                check("rdata", rdata, exp_q[0].data);
            end
            if (pp) void'(exp_q.pop_front());
            if (iss) begin
                d = model_mem[a];
`ifdef SRAM_RD_ARB_BYPASS_EN
                if (wr_en && wr_addr == a) d = wr_data;
`endif
                r.id = w;
                r.data = d;
                r.rdy = cyc + 2;
                exp_q.push_back(r);
                ptr = (w + 1) % int'(NREQ);
                last_aa = a;
                aa_known = 1'b1;
            end
        end
        if (gnt != '0) gcount++;
        if (wr_en) model_mem[wr_addr] = wr_data;
        rst_prev = rst;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_all_addr(input logic [WADDR-1:0] a);
        for (int i = 0; i < int'(NREQ); i++) addr[i*WADDR +: WADDR] = a + WADDR'(i);
    endtask

    logic [WWORD-1:0] v;

    initial begin
        checks = 0; failures = 0; cyc = 0; ptr = 0; gcount = 0;
        rst_prev = 1'b0; aa_known = 1'b0; last_aa = '0;
        rst = 1'b1; req = '0; addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            sram_mem[i] = v;
            model_mem[i] = v;
        end
        sram_mem[5] = {16{8'hA5}};  model_mem[5] = {16{8'hA5}};
        sram_mem[9] = 128'h11;      model_mem[9] = 128'h11;

        // Reset with no requests.
        @(posedge clk); #1;
        rst_prev = 1'b1;
        do_reset();
        repeat (3) tick();

        // Single read of address 5: grant now, data two cycles later.
        rready = 1'b1;
        addr[0 +: WADDR] = 11'd5;
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        check("lat_rvalid", {127'd0, rvalid}, 128'd1);
        check("lat_rid", {126'd0, rid}, '0);
        check("lat_rdata", rdata, {16{8'hA5}});
        repeat (3) tick();

        // All requesting: strict rotation, one grant per cycle.
        do_reset();
        set_all_addr(11'd20);
        req = 4'b1111;
        gcount = 0;
        repeat (12) tick();
        check("rr_rate", 128'(gcount), 128'd12);
        req = '0;
        repeat (3) tick();

        // Back-pressure: two grants then stall with a stable head.
        do_reset();
        set_all_addr(11'd40);
        rready = 1'b0;
        req = 4'b0011;
        gcount = 0;
        repeat (10) tick();
        check("stall_grants", 128'(gcount), 128'd2);
        rready = 1'b1;
        repeat (6) tick();

        // Reset with the FIFO full.
        rready = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
        rready = 1'b1;
        repeat (4) tick();
        req = 4'b1111;
        tick();
        req = '0;
        repeat (3) tick();

        // Reset during streaming (one queued, one in flight).
        req = 4'b1111;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
        repeat (4) tick();

        // Same-cycle write and read of address 9.
        addr[0 +: WADDR] = 11'd9;
        req = 4'b0001;
        wr_en = 1'b1; wr_addr = 11'd9; wr_data = 128'h22;
        tick();
        req = '0; wr_en = 1'b0;
        tick();
`ifdef SRAM_RD_ARB_BYPASS_EN
        check("bypass_rdata", rdata, 128'h22);
`else
        check("collide_rdata", rdata, 128'h11);
`endif
        repeat (3) tick();

        // Random traffic; requests stay up until the model grants them.
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    req[i] = 1'b1;
                    addr[i*WADDR +: WADDR] = WADDR'($urandom_range(0, 15));
                end
            end
            rready  = ($urandom_range(0, 3) != 0);
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = WADDR'($urandom_range(0, 15));
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
            req = req & ~gnt_exp;
        end
        req = '0; wr_en = 1'b0; rready = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
